// File: rtl/pipe_ctrl_if.sv
// Decode-side control bundle between the ID stage and the pipeline sequencing controller.
interface pipe_ctrl_if #(
    parameter int unsigned REG_W = 3
);
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic [REG_W-1:0] id_rdrq;
    logic [REG_W-1:0] id_rs;
    logic             id_use_rdrq;
    logic             id_use_rs;
    logic             id_write_en;
    logic [REG_W-1:0] id_write_reg;
    logic             ex_branch_taken;
    logic             resume;
    logic             stall;
    logic             bubble;
    logic             flush_ifid;
    logic             halted;
    logic             sb_busy;
    logic [1:0]       state;

    modport master (
        output id_valid, id_opcode, id_rdrq, id_rs, id_use_rdrq, id_use_rs,
               id_write_en, id_write_reg, ex_branch_taken, resume,
        input  stall, bubble, flush_ifid, halted, sb_busy, state
    );

    modport slave (
        input  id_valid, id_opcode, id_rdrq, id_rs, id_use_rdrq, id_use_rs,
               id_write_en, id_write_reg, ex_branch_taken, resume,
        output stall, bubble, flush_ifid, halted, sb_busy, state
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: shadow scoreboard of in-flight writes (EX/MEM/WB),
// RAW stall/bubble/flush generation and the halt/drain/resume state machine.
module pipe_ctrl #(
    parameter int unsigned REG_W  = 3,
    parameter int unsigned STAGES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(STAGES + 1);

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] wr_reg;
    } sb_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sb_entry_t        ex_q, mem_q, wb_q, ex_d;
    logic             raw_c, stall_c, bubble_c, flush_c;

    // WB is excluded: the register file is write-first.
    function automatic logic hit(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.valid & e.wr_en & (e.wr_reg == r);
    endfunction

    assign raw_c = bus.id_valid &
                   ((bus.id_use_rs   & (hit(ex_q, bus.id_rs)   | hit(mem_q, bus.id_rs))) |
                    (bus.id_use_rdrq & (hit(ex_q, bus.id_rdrq) | hit(mem_q, bus.id_rdrq))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= RUN;
            cnt_q <= '0;
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        ex_d     = '0;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        case (st_q)
            RUN: begin
                stall_c  = raw_c & ~bus.ex_branch_taken;
                bubble_c = stall_c | bus.ex_branch_taken;
                flush_c  = bus.ex_branch_taken;
                if (bus.id_valid & ~stall_c & ~bus.ex_branch_taken) begin
                    ex_d.valid  = 1'b1;
                    ex_d.wr_en  = bus.id_write_en & (bus.id_opcode != 4'd0);
                    ex_d.wr_reg = bus.id_write_reg;
                    if (bus.id_opcode == 4'd0) begin
                        st_d  = DRAIN;
                        cnt_d = CNT_W'(STAGES);
                    end
                end
            end
            DRAIN: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                if (cnt_q != '0) cnt_d = CNT_W'(cnt_q - CNT_W'(1));
                // WB retires on this edge, so only EX/MEM must be empty to finish.
                if ((cnt_q == CNT_W'(1)) && !ex_q.valid && !mem_q.valid) st_d = HALTED;
            end
            HALTED: begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                if (bus.resume) st_d = RUN;
            end
            default: st_d = RUN;
        endcase
    end

    assign bus.stall      = stall_c;
    assign bus.bubble     = bubble_c;
    assign bus.flush_ifid = flush_c;
    assign bus.halted     = (st_q == HALTED);
    assign bus.state      = st_q;
    assign bus.sb_busy    = (ex_q.valid & ex_q.wr_en) | (mem_q.valid & mem_q.wr_en) |
                            (wb_q.valid & wb_q.wr_en);
endmodule
